// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared types for the RAM arbiter. Holds the requester owner
//                encoding and the read-return tag carried through the
//                latency-matching pipeline.
//  Contents    : owner_e    - OWN_CPU = 0, OWN_LD = 1
//                rd_tag_t   - {valid, owner}
//                c_TAG_NONE - empty tag used for reset and write slots
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LD  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   localparam rd_tag_t c_TAG_NONE = '{valid: 1'b0, owner: OWN_CPU};

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : RD_LAT-deep shift register of read owner tags. A tag pushed
//                in the grant cycle pops out in the cycle the RAM presents
//                the matching read data.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_valid_i    - an accepted read this cycle
//                push_owner_i    - owner of that read (0 CPU, 1 loader)
//                pop_valid_o     - tag at pipeline output is a read
//                pop_owner_o     - owner of the popped read
//                busy_o          - any read still in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
   import ram_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic push_valid_i,
   input  logic push_owner_i,
   output logic pop_valid_o,
   output logic pop_owner_o,
   output logic busy_o
);

   rd_tag_t tag_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= c_TAG_NONE;
         end
      end else begin
         tag_q[0] <= '{valid: push_valid_i, owner: owner_e'(push_owner_i)};
         for (int i = 1; i < RD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign pop_valid_o = tag_q[RD_LAT-1].valid;
   assign pop_owner_o = tag_q[RD_LAT-1].owner;

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         busy_o = busy_o | tag_q[i].valid;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares a single-port RAM between the CPU and a program
//                loader/debug port. Round-robin arbitration with an optional
//                loader burst lock (bounded by MAX_LOCK), combinational grant,
//                and read data routed back through an owner tag pipeline.
//  Ports       : clk, rst                         - clock, sync reset (high)
//                cpu_req/we/addr/wdata -> cpu_gnt - CPU request side
//                cpu_rvalid, cpu_rdata            - CPU read return
//                ld_req/we/addr/wdata/lock        - loader request side
//                ld_gnt, ld_rvalid, ld_rdata      - loader grant / return
//                ram_addr/data/rden/wren, ram_q   - RAM interface
//                busy                             - reads in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_rden,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q,
   output logic          busy
);

   localparam int                c_CW       = $clog2(MAX_LOCK + 1);
   localparam logic [c_CW-1:0]   c_MAX_LOCK = c_CW'(MAX_LOCK);
   localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);

   localparam logic [0:0] c_UNLOCKED = 1'b0;
   localparam logic [0:0] c_LOCKED   = 1'b1;

   logic [0:0]      state_q, state_d;
   owner_e          prio_q, prio_d;
   logic [c_CW-1:0] lock_cnt_q, lock_cnt_d;
   logic            lock_hold;

   logic            pop_valid;
   logic            pop_owner;
   logic [DW-1:0]   cpu_rdata_q;
   logic [DW-1:0]   ld_rdata_q;

   // ------------------------------------------------------------------------
   // Grant. The lock overrides round-robin only while the burst count is
   // below MAX_LOCK; reset forces both grants low so the RAM sees no access
   // in the reset cycle.
   // ------------------------------------------------------------------------
   assign lock_hold = (state_q == c_LOCKED) && (lock_cnt_q < c_MAX_LOCK);

   always_comb begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (!rst) begin
         if (ld_req && lock_hold) begin
            ld_gnt = 1'b1;
         end else if (cpu_req && ld_req) begin
            if (prio_q == OWN_LD) begin
               ld_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (ld_req) begin
            ld_gnt = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // RAM command mux; idle bus drives zeros.
   // ------------------------------------------------------------------------
   always_comb begin
      ram_addr = '0;
      ram_data = '0;
      ram_rden = 1'b0;
      ram_wren = 1'b0;
      if (cpu_gnt) begin
         ram_addr = cpu_addr;
         ram_data = cpu_wdata;
         ram_rden = !cpu_we;
         ram_wren = cpu_we;
      end else if (ld_gnt) begin
         ram_addr = ld_addr;
         ram_data = ld_wdata;
         ram_rden = !ld_we;
         ram_wren = ld_we;
      end
   end

   // ------------------------------------------------------------------------
   // Priority and lock state.
   // ------------------------------------------------------------------------
   always_comb begin
      prio_d     = prio_q;
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;

      if (cpu_gnt) begin
         prio_d = OWN_LD;
      end else if (ld_gnt) begin
         prio_d = OWN_CPU;
      end

      case (state_q)
         c_UNLOCKED: begin
            if (ld_gnt && ld_lock) begin
               state_d    = c_LOCKED;
               lock_cnt_d = c_CNT_ONE;
            end
         end
         c_LOCKED: begin
            // A loader that idles for a cycle or drops ld_lock ends the
            // burst; its final transfer (if any) is still granted.
            if (!ld_req || !ld_lock) begin
               state_d    = c_UNLOCKED;
               lock_cnt_d = '0;
            end else if (ld_gnt) begin
               lock_cnt_d = lock_cnt_q + c_CNT_ONE;
            end
         end
         default: begin
            state_d    = c_UNLOCKED;
            lock_cnt_d = '0;
         end
      endcase

      // Burst limit reached: hand the next turn to the CPU.
      if ((state_d == c_LOCKED) && (lock_cnt_d >= c_MAX_LOCK)) begin
         state_d    = c_UNLOCKED;
         lock_cnt_d = '0;
         prio_d     = OWN_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= c_UNLOCKED;
         prio_q     <= OWN_CPU;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read return. Tags are pushed with the grant and pop in step with ram_q.
   // ------------------------------------------------------------------------
   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (ram_rden),
      .push_owner_i (ld_gnt),
      .pop_valid_o  (pop_valid),
      .pop_owner_o  (pop_owner),
      .busy_o       (busy)
   );

   // Gating with rst discards reads caught in flight by a reset.
   assign cpu_rvalid = !rst && pop_valid && (pop_owner == OWN_CPU);
   assign ld_rvalid  = !rst && pop_valid && (pop_owner == OWN_LD);

   // Returning side sees ram_q directly; the other side holds its last word.
   assign cpu_rdata = cpu_rvalid ? ram_q : cpu_rdata_q;
   assign ld_rdata  = ld_rvalid  ? ram_q : ld_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
      end else begin
         if (cpu_rvalid) begin
            cpu_rdata_q <= ram_q;
         end
         if (ld_rvalid) begin
            ld_rdata_q <= ram_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. A driver issues
//                directed and random requests, predicts grants and RAM
//                commands from a behavioural model, and queues expected read
//                returns; a monitor pops the queue and checks rvalid, rdata
//                and busy every cycle. A behavioural RAM sits on the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int AW       = 8;
   localparam int DW       = 8;
   localparam int RD_LAT   = 1;
   localparam int MAX_LOCK = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata, ld_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data, ram_q;
   logic          ram_rden, ram_wren, busy;

   always #5 clk = ~clk;

   ram_arbiter #(
      .AW (AW), .DW (DW), .RD_LAT (RD_LAT), .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk (clk), .rst (rst),
      .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
      .cpu_wdata (cpu_wdata), .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .ld_req (ld_req), .ld_we (ld_we), .ld_addr (ld_addr),
      .ld_wdata (ld_wdata), .ld_lock (ld_lock), .ld_gnt (ld_gnt),
      .ld_rvalid (ld_rvalid), .ld_rdata (ld_rdata),
      .ram_addr (ram_addr), .ram_data (ram_data), .ram_rden (ram_rden),
      .ram_wren (ram_wren), .ram_q (ram_q), .busy (busy)
   );

   // Initial RAM contents are a fixed function of the address.
   function automatic logic [7:0] init_val(input logic [7:0] a);
      return (a * 8'd7) ^ 8'h3C;
   endfunction

   // ---------------- behavioural single-port RAM, one-cycle read ----------
   logic       mem_init;
   logic [7:0] ram_mem [256];
   logic       ram_wr  [256];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) ram_wr[i] <= 1'b0;
         ram_q <= 8'h00;
      end else begin
         if (ram_wren) begin
            ram_mem[ram_addr] <= ram_data;
            ram_wr[ram_addr]  <= 1'b1;
         end
         if (ram_rden) ram_q <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
      end
   end

   // ---------------- checking infrastructure ------------------------------
   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      bit         own_ld;
      logic [7:0] data;
      int         gcyc;
      int         due;
   } rd_exp_t;

   rd_exp_t sb [$];

   // ---------------- reference model state --------------------------------
   bit         m_fav_ld;      // loader wins a tie
   int         m_burst;       // locked loader transfers so far, 0 = none
   logic [7:0] mdl_mem [256];
   bit         mdl_wr  [256];

   // One bus cycle: inputs are already applied; predict, compare, advance.
   task automatic cycle(output bit gc, output bit gl, output bit ac, output bit al);
      bit         ec, el, erd, ewr, we;
      logic [7:0] ea, ed;
      cyc++;
      @(negedge clk);
      ec = 1'b0;
      el = 1'b0;
      if (!rst) begin
         if (ld_req && m_burst > 0 && m_burst < MAX_LOCK) el = 1'b1;
         else if (cpu_req && ld_req) begin
            if (m_fav_ld) el = 1'b1; else ec = 1'b1;
         end
         else if (cpu_req) ec = 1'b1;
         else if (ld_req)  el = 1'b1;
      end
      ea  = ec ? cpu_addr  : (el ? ld_addr  : 8'h00);
      ed  = ec ? cpu_wdata : (el ? ld_wdata : 8'h00);
      we  = ec ? cpu_we : ld_we;
      erd = (ec || el) && !we;
      ewr = (ec || el) && we;
      check("gnt", 32'({cpu_gnt, ld_gnt}), 32'({ec, el}));
      check("ram_bus", 32'({ram_rden, ram_wren, ram_addr, ram_data}), 32'({erd, ewr, ea, ed}));

      if (rst) begin
         m_fav_ld = 1'b0;
         m_burst  = 0;
      end else begin
         if (ec || el) begin
            if (we) begin
               mdl_mem[ea] = ed;
               mdl_wr[ea]  = 1'b1;
            end else begin
               sb.push_back('{own_ld: el, data: (mdl_wr[ea] ? mdl_mem[ea] : init_val(ea)),
                              gcyc: cyc, due: cyc + RD_LAT});
            end
         end
         if (m_burst > 0) begin
            if (!ld_req || !ld_lock) m_burst = 0;
            else if (el)             m_burst = m_burst + 1;
         end else if (el && ld_lock) begin
            m_burst = 1;
         end
         if (m_burst >= MAX_LOCK) m_burst = 0;
         if (ec)      m_fav_ld = 1'b1;
         else if (el) m_fav_ld = 1'b0;
      end
      gc = ec;
      gl = el;
      ac = cpu_gnt;
      al = ld_gnt;
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor: read returns and busy -----------------------
   logic [7:0] last_c = 8'h00;
   logic [7:0] last_l = 8'h00;
   bit         m_cv, m_lv, m_busy;
   rd_exp_t    m_it;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            m_busy = 1'b0;
            foreach (sb[i]) if (sb[i].gcyc < cyc) m_busy = 1'b1;
            m_cv = 1'b0;
            m_lv = 1'b0;
            if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
               m_it = sb.pop_front();
               if (m_it.own_ld) begin
                  m_lv   = 1'b1;
                  last_l = m_it.data;
               end else begin
                  m_cv   = 1'b1;
                  last_c = m_it.data;
               end
            end
            check("rvalid", 32'({cpu_rvalid, ld_rvalid}), 32'({m_cv, m_lv}));
            check("cpu_rdata", 32'(cpu_rdata), 32'(last_c));
            check("ld_rdata", 32'(ld_rdata), 32'(last_l));
            check("busy", 32'(busy), 32'(m_busy));
            if (rst) begin
               sb.delete();
               last_c = 8'h00;
               last_l = 8'h00;
            end
         end
      end
   end

   // ---------------- stimulus ---------------------------------------------
   bit gc, gl, ac, al;
   int k, run;
   bit cpu_pend, ld_pend, lk_mode;
   bit seq_c [$];
   bit seq_l [$];

   initial begin
      for (int i = 0; i < 256; i++) mdl_wr[i] = 1'b0;
      m_fav_ld = 1'b0;
      m_burst  = 0;
      rst = 1'b1; mem_init = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00; ld_lock = 1'b0;
      @(posedge clk);
      #1;
      mem_init = 1'b0;
      mon_en   = 1'b1;

      // Reset held with a pending CPU read: nothing granted, then granted.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
      repeat (2) cycle(gc, gl, ac, al);
      rst = 1'b0;
      cycle(gc, gl, ac, al);
      cpu_req = 1'b0;

      // Contention: both read every cycle.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h80; ld_lock = 1'b0;
      repeat (8) cycle(gc, gl, ac, al);

      // Locked loader burst of 20 writes against a persistent CPU reader.
      cpu_addr = 8'h44;
      k = 0;
      ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 8'h00; ld_wdata = 8'($urandom);
      for (int t = 0; t < 60 && k < 20; t++) begin
         cycle(gc, gl, ac, al);
         seq_c.push_back(ac);
         seq_l.push_back(al);
         if (gl) begin
            k++;
            ld_addr  = 8'(k);
            ld_wdata = 8'($urandom);
         end
      end
      check("burst_done", 32'(k), 32'd20);
      ld_req = 1'b0; ld_lock = 1'b0;
      run = 0;
      k = 0;
      while (k < seq_l.size() && !seq_l[k]) k++;
      while (k < seq_l.size() && seq_l[k]) begin
         run++;
         k++;
      end
      check("burst_run", 32'(run), 32'(MAX_LOCK));
      check("burst_cpu_turn", 32'((k < seq_c.size()) ? seq_c[k] : 1'b0), 32'd1);

      // Lock dropped on the fourth loader write: CPU is served next.
      cpu_addr = 8'h45;
      ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 8'h60; ld_wdata = 8'h11;
      k = 0;
      for (int t = 0; t < 20 && k < 4; t++) begin
         cycle(gc, gl, ac, al);
         if (gl) begin
            k++;
            ld_addr  = 8'(8'h60 + k);
            ld_wdata = 8'($urandom);
            ld_lock  = (k < 3);
         end
      end
      check("lock_writes", 32'(k), 32'd4);
      cycle(gc, gl, ac, al);
      check("lock_release_next", 32'({ac, al}), 32'b10);
      cpu_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
      cycle(gc, gl, ac, al);

      // CPU read immediately followed by reset.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
      cycle(gc, gl, ac, al);
      cpu_req = 1'b0; rst = 1'b1;
      cycle(gc, gl, ac, al);
      rst = 1'b0;
      cycle(gc, gl, ac, al);

      // Loader write then CPU read of the same address.
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h5A;
      cycle(gc, gl, ac, al);
      ld_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      cycle(gc, gl, ac, al);
      cpu_req = 1'b0;
      repeat (2) cycle(gc, gl, ac, al);

      // Random traffic with occasional lock bursts and resets.
      cpu_pend = 1'b0; ld_pend = 1'b0; lk_mode = 1'b0;
      for (int t = 0; t < 600; t++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) lk_mode = !lk_mode;
         if (!cpu_pend && $urandom_range(0, 99) < 60) begin
            cpu_pend  = 1'b1;
            cpu_we    = 1'($urandom);
            cpu_addr  = 8'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom);
         end
         if (!ld_pend && $urandom_range(0, 99) < (lk_mode ? 90 : 50)) begin
            ld_pend  = 1'b1;
            ld_we    = 1'($urandom);
            ld_addr  = 8'($urandom_range(0, 31));
            ld_wdata = 8'($urandom);
            ld_lock  = lk_mode && ($urandom_range(0, 15) != 0);
         end
         cpu_req = cpu_pend;
         ld_req  = ld_pend;
         cycle(gc, gl, ac, al);
         if (gc) cpu_pend = 1'b0;
         if (gl) ld_pend  = 1'b0;
      end
      rst = 1'b0; cpu_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
      repeat (RD_LAT + 2) cycle(gc, gl, ac, al);
      check("drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8-bit RAM between two requesters: the CPU fetch/exec path (stage/pc/ir datapath) and a program loader/debug port.
- Performs round-robin arbitration with an optional loader lock for bursts, and drives the RAM address, data, rden and wren.
- Routes read data back to the requester that issued the read, using a latency-matched owner tag pipeline.
- Sits between the CPU datapath and the ram instance.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in cycles from the accepted read to valid ram_q; legal range 1..4.
- MAX_LOCK, 16, maximum consecutive loader transfers under lock before the arbiter forces a CPU turn.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU requests a transfer.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DW  CPU read data.
- ld_req  in  1  loader requests a transfer.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_lock  in  1  loader asks to retain ownership for a burst.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  ld_rdata valid.
- ld_rdata  out  DW  loader read data.
- ram_addr  out  AW  RAM address.
- ram_data  out  DW  RAM write data.
- ram_rden  out  1  RAM read enable.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DW  RAM read data.
- busy  out  1  any read still in flight.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Transfer rule: a transfer happens in any cycle where req && gnt.
  - The requester holds req, we, addr and wdata stable until it samples gnt = 1.
  - Each transfer is exactly one cycle; there is no wait state.
- Grant logic:
  - Grant is combinational from the requests and registered state: prio (0 = CPU favoured, 1 = loader favoured), locked and lock_cnt.
  - At most one gnt is high per cycle.
  - When only one requester is active, it is granted.
  - When both request, the favoured side is granted.
  - While locked = 1 and lock_cnt < MAX_LOCK, the loader is granted whenever ld_req = 1, even if the CPU is favoured.
- Priority update: after each transfer, prio points to the other requester (round-robin).
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on a loader transfer with ld_lock = 1; lock_cnt is set to 1.
  - In LOCKED, each loader transfer increments lock_cnt.
  - LOCKED -> UNLOCKED when any of the following holds:
    - ld_lock = 0 is sampled in a cycle where ld_req = 1;
    - ld_req = 0 for one cycle;
    - lock_cnt reaches MAX_LOCK. In that case the next grant goes to the CPU if cpu_req = 1, and prio = 0.
- RAM outputs:
  - ram_addr and ram_data are muxed from the granted requester; they are 0 when nothing is granted.
  - ram_rden = gnt && !we.
  - ram_wren = gnt && we.
  - rden and wren are never high together.
- Read return:
  - Each accepted read pushes an owner tag (valid, owner) into an RD_LAT-deep shift register.
  - At the pipeline output, the owner's rvalid = 1 and its rdata = ram_q.
  - The other side's rdata holds its last value.
  - Writes push an invalid tag.
  - Back-to-back reads alternating between owners return in issue order, each RD_LAT cycles after its grant.
- busy = OR of the tag-pipeline valid bits.
- Reset values:
  - gnt outputs 0; ram_rden and ram_wren 0; ram_addr and ram_data 0.
  - Tag pipeline cleared; rvalid outputs 0; rdata registers 0.
  - prio = 0; state UNLOCKED; lock_cnt = 0; busy 0.
- Reset mid-operation: in-flight reads are discarded with no rvalid. RAM enables are low in the reset cycle itself, because gnt is forced to 0 while rst = 1.
- Simultaneous events:
  - A loader lock request and a CPU request in the same cycle with the CPU favoured: the CPU wins and the lock is not entered.
  - Write followed by read of the same address: the RAM defines the result; the arbiter adds no forwarding.

Decomposition:
- Shared package: owner encoding (OWN_CPU = 0, OWN_LD = 1) and the tag struct {valid, owner}.
- Sub-module rd_tag_pipe:
  - Parameterised by RD_LAT.
  - Inputs: push valid/owner. Outputs: pop valid/owner and busy.
  - Keeps the arbiter FSM separate from latency matching.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles while cpu_req = 1 -> cpu_gnt = 0, ram_rden = 0, busy = 0. First cycle after release -> cpu_gnt = 1, ram_addr = cpu_addr.
- Contention: both request reads every cycle, CPU addr 0x10, loader addr 0x80 -> grants alternate CPU, LD, CPU, LD. Each rvalid appears RD_LAT = 1 cycle after its grant with the correct ram_q.
- Loader burst: ld_lock = 1 with writes 0x00..0x13 and cpu_req held -> loader gets 16 consecutive grants, the CPU gets 1 grant, then the loader resumes.
- Lock release: ld_lock dropped after 3 writes with cpu_req = 1 -> the next grant goes to the CPU and the state is UNLOCKED.
- Mid-read reset: CPU read granted at cycle N, rst = 1 at N+1 -> no cpu_rvalid at N+1 and busy = 0 after reset.
- Write/read ordering: loader writes 0x5A to 0x20, then the CPU reads 0x20 -> cpu_rdata = 0x5A with cpu_rvalid = 1, and ld_rvalid stays 0 throughout.
